// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, VGA line-fetch and memory-side signals of the
// data-memory arbiter; slave = arbiter view, master = client/memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [LEN_W-1:0]  vga_len;
  logic              vga_gnt;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;
  logic              vga_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  vga_req, vga_addr, vga_len,
    output vga_gnt, vga_rdata, vga_rvalid, vga_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output vga_req, vga_addr, vga_len,
    input  vga_gnt, vga_rdata, vga_rvalid, vga_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-priority data-memory arbiter with bounded VGA bursts.
// Optional DMEM_ARB_STATS_EN adds stall and burst counters.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int BURST_MAX    = 16,
  parameter int LEN_W        = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic         clk,
  input  logic         reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]  stat_cpu_stall,
  output logic [31:0]  stat_vga_bursts
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    VGA_BURST,
    VGA_DRAIN
  } state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(BURST_MAX);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t            r_state;
  logic [SW-1:0]     r_starve;
  logic [LEN_W-1:0]  r_rem;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;

  logic              w_idle;
  logic              w_burst;
  logic              w_drain;
  logic              w_vga_win;
  logic              w_cpu_win;
  logic              w_cpu_wr;
  logic              w_cpu_rd;
  logic              w_stall;
  logic              w_gnt;
  logic [LEN_W-1:0]  w_len_in;

  assign w_idle  = (r_state == IDLE);
  assign w_burst = (r_state == VGA_BURST);
  assign w_drain = (r_state == VGA_DRAIN);

  assign w_vga_win = w_idle & bus.vga_req
                   & (~bus.cpu_req | (r_starve >= STARVE_MAX));
  assign w_cpu_win = w_idle & bus.cpu_req & ~w_vga_win;
  assign w_cpu_wr  = w_cpu_win & bus.cpu_we;
  assign w_cpu_rd  = w_cpu_win & ~bus.cpu_we;

  assign w_len_in = (bus.vga_len > LEN_MAX) ? LEN_MAX : bus.vga_len;

  // Request-driven outputs are forced low while reset is held.
  assign w_gnt   = reset & w_vga_win;
  assign w_stall = reset & bus.cpu_req
                 & (w_burst | w_drain | w_vga_win | w_cpu_rd);

  assign bus.vga_gnt    = w_gnt;
  assign bus.cpu_stall  = w_stall;
  assign bus.vga_rvalid = r_rvalid;
  assign bus.vga_rdata  = r_rvalid ? bus.mem_rdata : '0;
  assign bus.vga_done   = w_drain;
  assign bus.cpu_rdata  = (r_state == CPU_RD) ? bus.mem_rdata
                                               : r_cpu_rdata;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (reset) begin
      unique case (1'b1)
        w_cpu_wr: begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.cpu_addr;
          bus.mem_wdata = bus.cpu_wdata;
        end
        w_cpu_rd: begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = bus.cpu_addr;
        end
        w_burst: begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = r_addr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_rem       <= '0;
      r_addr      <= '0;
      r_rvalid    <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_rvalid <= w_burst;
      if (w_vga_win)
        r_starve <= '0;
      else if (bus.vga_req && (r_starve < STARVE_MAX))
        r_starve <= r_starve + 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_vga_win) begin
            r_addr  <= bus.vga_addr;
            r_rem   <= w_len_in;
            r_state <= (w_len_in == '0) ? VGA_DRAIN : VGA_BURST;
          end else if (w_cpu_rd) begin
            r_state <= CPU_RD;
          end
        end
        CPU_RD: begin
          r_cpu_rdata <= bus.mem_rdata;
          r_state     <= IDLE;
        end
        VGA_BURST: begin
          r_addr <= r_addr + 1'b1;
          r_rem  <= r_rem - 1'b1;
          if (r_rem == LEN_ONE)
            r_state <= VGA_DRAIN;
        end
        VGA_DRAIN: r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stat_stall;
  logic [31:0] r_stat_bursts;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_stall  <= '0;
      r_stat_bursts <= '0;
    end else begin
      if (w_stall && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 32'd1;
      if (w_gnt && (r_stat_bursts != '1))
        r_stat_bursts <= r_stat_bursts + 32'd1;
    end
  end

  assign stat_cpu_stall  = r_stat_stall;
  assign stat_vga_bursts = r_stat_bursts;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter
// against a transaction-level memory model.
module tb_dmem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LW   = 5;
  localparam int BMAX = 16;
  localparam int SLIM = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_cpu_stall;
  logic [31:0] stat_vga_bursts;
`endif

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BMAX),
    .LEN_W(LW), .STARVE_LIMIT(SLIM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_cpu_stall(stat_cpu_stall),
    .stat_vga_bursts(stat_vga_bursts)
`endif
  );

  // Environment memory: contents default to the address; CPU writes land in 0..255.
  bit [31:0] env_wmem [256];
  bit        env_wval [256];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we && bus.mem_addr < 256) begin
      env_wmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      env_wval[bus.mem_addr[7:0]] <= 1'b1;
    end
    if (bus.mem_en && !bus.mem_we) begin
      if (bus.mem_addr < 256 && env_wval[bus.mem_addr[7:0]])
        bus.mem_rdata <= env_wmem[bus.mem_addr[7:0]];
      else
        bus.mem_rdata <= bus.mem_addr;
    end
  end

  // Reference model of memory contents as the CPU should see them.
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.vga_req   = 1'b0;
    bus.vga_addr  = '0;
    bus.vga_len   = '0;
  endtask

  task automatic test_reset();
    logic [7:0] f;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'h1234;
    bus.vga_req = 1'b1; bus.vga_addr = 32'h80; bus.vga_len = 5'd4;
    reset = 1'b0;
    @(negedge clk);
    f = {bus.cpu_stall, bus.vga_gnt, bus.vga_rvalid, bus.vga_done,
         bus.mem_en, bus.mem_we, 2'b00};
    n_chk++; if (f !== 8'h00) $display("FAIL reset_flags got %h want 00", f); else n_pass++;
    n_chk++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); else n_pass++;
    n_chk++; if (bus.cpu_rdata !== 32'h0) $display("FAIL reset_cpu_rdata got %h want 0", bus.cpu_rdata); else n_pass++;
    n_chk++; if (bus.mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); else n_pass++;
`ifdef DMEM_ARB_STATS_EN
    n_chk++; if ({stat_cpu_stall, stat_vga_bursts} !== 64'h0) $display("FAIL reset_stats got %h/%h want 0/0", stat_cpu_stall, stat_vga_bursts); else n_pass++;
`endif
    idle_inputs();
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_cpu_rw();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_chk++; if ({bus.mem_en, bus.mem_we, bus.cpu_stall} !== 3'b110) $display("FAIL wr_ctrl got %b want 110", {bus.mem_en, bus.mem_we, bus.cpu_stall}); else n_pass++;
    n_chk++; if ({bus.mem_addr, bus.mem_wdata} !== {32'h10, 32'hDEADBEEF}) $display("FAIL wr_bus got %h/%h want 10/deadbeef", bus.mem_addr, bus.mem_wdata); else n_pass++;
    ref_mem[32'h10] = 32'hDEADBEEF;
    cyc();
    bus.cpu_we = 1'b0;
    @(negedge clk);
    n_chk++; if ({bus.mem_en, bus.mem_we, bus.cpu_stall} !== 3'b101) $display("FAIL rd_issue got %b want 101", {bus.mem_en, bus.mem_we, bus.cpu_stall}); else n_pass++;
    cyc();
    @(negedge clk);
    n_chk++; if ({bus.mem_en, bus.cpu_stall} !== 2'b00) $display("FAIL rd_done_ctrl got %b want 00", {bus.mem_en, bus.cpu_stall}); else n_pass++;
    n_chk++; if (bus.cpu_rdata !== ref_rd(32'h10)) $display("FAIL rd_data got %h want %h", bus.cpu_rdata, ref_rd(32'h10)); else n_pass++;
    cyc();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.cpu_rdata !== ref_rd(32'h10)) $display("FAIL rd_hold got %h want %h", bus.cpu_rdata, ref_rd(32'h10)); else n_pass++;
    cyc();
  endtask

  task automatic test_vga_bursts();
    logic [31:0] adr [4];
    int          lens [4];
    adr  = '{32'h100, 32'h40, 32'h500, 32'hFFFFFFFE};
    lens = '{4, 0, 20, 3};
    for (int t = 0; t < 4; t++) begin
      int n;
      n = (lens[t] > BMAX) ? BMAX : lens[t];
      bus.vga_req = 1'b1; bus.vga_addr = adr[t]; bus.vga_len = LW'(lens[t]);
      @(negedge clk);
      n_chk++; if ({bus.vga_gnt, bus.mem_en} !== 2'b10) $display("FAIL burst%0d_gnt got %b want 10", t, {bus.vga_gnt, bus.mem_en}); else n_pass++;
      cyc();
      bus.vga_req = 1'b0;
      for (int c = 1; c <= n + 2; c++) begin
        logic [31:0] ea;
        logic [31:0] ed;
        logic        rv;
        ea = adr[t] + 32'(c - 1);
        ed = ref_rd(adr[t] + 32'(c - 2));
        rv = (c >= 2) && (c <= n + 1);
        @(negedge clk);
        n_chk++; if (bus.mem_en !== (c <= n)) $display("FAIL burst%0d_en c%0d got %b want %b", t, c, bus.mem_en, (c <= n)); else n_pass++;
        if (c <= n) begin
          n_chk++; if ({bus.mem_we, bus.mem_addr} !== {1'b0, ea}) $display("FAIL burst%0d_addr c%0d got %h want %h", t, c, bus.mem_addr, ea); else n_pass++;
        end
        n_chk++; if (bus.vga_rvalid !== rv) $display("FAIL burst%0d_rvalid c%0d got %b want %b", t, c, bus.vga_rvalid, rv); else n_pass++;
        if (rv) begin
          n_chk++; if (bus.vga_rdata !== ed) $display("FAIL burst%0d_rdata c%0d got %h want %h", t, c, bus.vga_rdata, ed); else n_pass++;
        end
        n_chk++; if ({bus.vga_done, bus.vga_gnt} !== {(c == n + 1), 1'b0}) $display("FAIL burst%0d_done c%0d got %b want %b", t, c, {bus.vga_done, bus.vga_gnt}, {(c == n + 1), 1'b0}); else n_pass++;
        cyc();
      end
    end
  endtask

  task automatic test_starvation();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 32'h30; bus.cpu_wdata = 32'hA5A50030;
    bus.vga_req = 1'b1; bus.vga_addr = 32'h200; bus.vga_len = 5'd2;
    for (int w = 1; w <= SLIM + 1; w++) begin
      logic [2:0] e;
      e = (w <= SLIM) ? 3'b001 : 3'b110;
      @(negedge clk);
      n_chk++; if ({bus.vga_gnt, bus.cpu_stall, bus.mem_we} !== e) $display("FAIL starve_w%0d got %b want %b", w, {bus.vga_gnt, bus.cpu_stall, bus.mem_we}, e); else n_pass++;
      cyc();
    end
    ref_mem[32'h30] = 32'hA5A50030;
    bus.vga_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_chk++; if ({bus.cpu_stall, bus.mem_en} !== {1'b1, (c <= 2)}) $display("FAIL starve_burst c%0d got %b want %b", c, {bus.cpu_stall, bus.mem_en}, {1'b1, (c <= 2)}); else n_pass++;
      cyc();
    end
    @(negedge clk);
    n_chk++; if ({bus.cpu_stall, bus.mem_we} !== 2'b01) $display("FAIL starve_resume got %b want 01", {bus.cpu_stall, bus.mem_we}); else n_pass++;
    cyc();
    bus.cpu_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] f;
    bus.vga_req = 1'b1; bus.vga_addr = 32'h600; bus.vga_len = 5'd8;
    @(negedge clk);
    n_chk++; if (bus.vga_gnt !== 1'b1) $display("FAIL rst_burst_gnt got %b want 1", bus.vga_gnt); else n_pass++;
    cyc();
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    @(negedge clk);
    n_chk++; if ({bus.mem_en, bus.cpu_stall} !== 2'b11) $display("FAIL rst_burst_issue got %b want 11", {bus.mem_en, bus.cpu_stall}); else n_pass++;
    cyc();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) #1; else @(negedge clk);
      f = {bus.cpu_stall, bus.vga_gnt, bus.vga_rvalid, bus.vga_done,
           bus.mem_en, bus.mem_we, 2'b00};
      n_chk++; if (f !== 8'h00) $display("FAIL rst_mid_flags c%0d got %h want 00", c, f); else n_pass++;
      n_chk++; if ({bus.mem_addr, bus.vga_rdata, bus.cpu_rdata} !== 96'h0) $display("FAIL rst_mid_data c%0d got %h/%h/%h want 0", c, bus.mem_addr, bus.vga_rdata, bus.cpu_rdata); else n_pass++;
    end
    cyc();
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if ({bus.cpu_stall, bus.mem_en, bus.vga_done, bus.vga_rvalid} !== 4'b1100) $display("FAIL rst_after_rd got %b want 1100", {bus.cpu_stall, bus.mem_en, bus.vga_done, bus.vga_rvalid}); else n_pass++;
    n_chk++; if (bus.mem_addr !== 32'h10) $display("FAIL rst_after_addr got %h want 10", bus.mem_addr); else n_pass++;
    cyc();
    @(negedge clk);
    n_chk++; if ({bus.cpu_stall, bus.cpu_rdata} !== {1'b0, ref_rd(32'h10)}) $display("FAIL rst_after_data got %b/%h want 0/%h", bus.cpu_stall, bus.cpu_rdata, ref_rd(32'h10)); else n_pass++;
    cyc();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.vga_done !== 1'b0) $display("FAIL rst_after_done got %b want 0", bus.vga_done); else n_pass++;
    cyc();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    bit ok;
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    cyc();
    cyc();
    bus.cpu_req = 1'b0;
    bus.vga_req = 1'b1; bus.vga_addr = 32'h100; bus.vga_len = 5'd4;
    cyc();
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (!bus.cpu_stall) ok = 1'b1;
    end
    if (!ok) begin n_chk++; $display("FAIL stats_timeout cpu never released"); end
    cyc();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    n_chk++; if (stat_vga_bursts !== 32'd1) $display("FAIL stat_bursts got %0d want 1", stat_vga_bursts); else n_pass++;
    n_chk++; if (stat_cpu_stall !== 32'(1 + 4 + 1 + 1)) $display("FAIL stat_stall got %0d want %0d", stat_cpu_stall, 1 + 4 + 1 + 1); else n_pass++;
    cyc();
  endtask
`endif

  task automatic cpu_op(input bit we, input logic [31:0] a,
                        input logic [31:0] d, input int dly);
    bit ok;
    ok = 1'b0;
    repeat (dly) cyc();
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (!bus.cpu_stall) begin
        ok = 1'b1;
        if (we) begin
          n_chk++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, a, d}) $display("FAIL rnd_wr a=%h got %b%b/%h/%h want 11/%h/%h", a, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, a, d); else n_pass++;
          ref_mem[a] = d;
        end else begin
          n_chk++; if (bus.cpu_rdata !== ref_rd(a)) $display("FAIL rnd_rd a=%h got %h want %h", a, bus.cpu_rdata, ref_rd(a)); else n_pass++;
        end
      end
    end
    if (!ok) begin n_chk++; $display("FAIL rnd_cpu_timeout a=%h", a); end
    cyc();
    bus.cpu_req = 1'b0;
  endtask

  task automatic vga_op(input logic [31:0] a, input int len, input int dly);
    int n;
    int got;
    bit g;
    bit dn;
    n = (len > BMAX) ? BMAX : len;
    got = 0; g = 1'b0; dn = 1'b0;
    repeat (dly) cyc();
    bus.vga_req = 1'b1; bus.vga_addr = a; bus.vga_len = LW'(len);
    for (int k = 0; k < 60 && !g; k++) begin
      @(negedge clk);
      if (bus.vga_gnt) g = 1'b1;
    end
    if (!g) begin n_chk++; $display("FAIL rnd_gnt_timeout a=%h", a); end
    cyc();
    bus.vga_req = 1'b0;
    for (int k = 0; k < 40 && !dn; k++) begin
      @(negedge clk);
      if (bus.vga_rvalid) begin
        n_chk++; if (bus.vga_rdata !== ref_rd(a + 32'(got))) $display("FAIL rnd_vdata a=%h w%0d got %h want %h", a, got, bus.vga_rdata, ref_rd(a + 32'(got))); else n_pass++;
        got++;
      end
      if (bus.vga_done) begin
        dn = 1'b1;
        n_chk++; if (got !== n) $display("FAIL rnd_vcount a=%h got %0d want %0d", a, got, n); else n_pass++;
      end
    end
    if (!dn) begin n_chk++; $display("FAIL rnd_done_timeout a=%h", a); end
    cyc();
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      fork
        if (kind != 1)
          cpu_op(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                 $urandom, int'($urandom_range(0, 2)));
        if (kind != 0)
          vga_op(32'($urandom_range(0, 511)),
                 int'($urandom_range(0, 20)), int'($urandom_range(0, 2)));
      join
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_rw();
    test_vga_bursts();
    test_starvation();
    test_reset_mid_burst();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
